// File: rtl/multi_edge_pkg.sv
// Shared constants and helpers for the multi-channel debounced edge detector.
// Optional feature macro: MULTI_EDGE_SYNC_EN (adds a 2-flop input synchronizer per channel).
package multi_edge_pkg;

  // Tick select encodings, shared by all channels.
  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  // Default number of consecutive differing samples needed to accept a new level.
  localparam int unsigned DEB_CYCLES_DEFAULT = 16;

  // Selects which accepted edge(s) produce a tick for a given mode.
  function automatic logic tick_sel(input logic [1:0] mode, input logic rise, input logic fall);
    logic t;
    case (mode)
      MODE_RISE: t = rise;
      MODE_FALL: t = fall;
      MODE_BOTH: t = rise | fall;
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/multi_edge_detect_if.sv
// Bundle of per-channel level inputs, shared mode select and per-channel outputs.
// Optional feature macro: MULTI_EDGE_SYNC_EN (no effect on this interface).
interface multi_edge_detect_if #(
  parameter int unsigned CH = 4
);

  logic [CH-1:0] level;
  logic [1:0]    mode;
  logic [CH-1:0] stable;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] tick;

  // Driver side: raw pins and mode in, debounced results out.
  modport master (
    output level,
    output mode,
    input  stable,
    input  rise,
    input  fall,
    input  tick
  );

  // Detector side.
  modport slave (
    input  level,
    input  mode,
    output stable,
    output rise,
    output fall,
    output tick
  );

endinterface

// File: rtl/multi_edge_detect_debounce_channel.sv
// One debounce channel: optional synchronizer, consecutive-sample counter, stable level
// register and registered rise/fall pulses. Also exposes the combinational accept strobes
// so the top can capture mode on the accepting edge.
// Optional feature macro: MULTI_EDGE_SYNC_EN (2-flop synchronizer in front of the counter).
module debounce_channel
  import multi_edge_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic acc_rise_o,
  output logic acc_fall_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);

  logic sample;

`ifdef MULTI_EDGE_SYNC_EN
  logic [1:0] sync_d, sync_q;

  // Shift the raw pin through two flops before it is allowed near the counter.
  always_comb begin
    sync_d = {sync_q[0], level_i};
  end

  // Synchronizer flops, cleared by reset so no spurious edge is seen on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sample = sync_q[1];
`else
  assign sample = level_i;
`endif

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             stable_d, stable_q;
  logic             rise_d, rise_q;
  logic             fall_d, fall_q;

  // Debounce: count consecutive differing samples, accept on the DEB_CYCLES-th one.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sample == stable_q) begin
      // Any agreeing sample restarts the debounce window.
      cnt_d = '0;
    end else if (cnt_q >= CntMax) begin
      // >= keeps the counter from ever passing CntMax, even from a corrupted state.
      stable_d = sample;
      cnt_d    = '0;
      rise_d   = sample;
      fall_d   = ~sample;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o   = stable_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign acc_rise_o = rise_d;
  assign acc_fall_o = fall_d;

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel debounced edge detector. CH independent debounce channels plus a shared
// mode-selected tick, registered so mode is sampled on the accepting edge only.
// Optional feature macro: MULTI_EDGE_SYNC_EN (per-channel 2-flop synchronizer, +2 cycles).
module multi_edge_detect
  import multi_edge_pkg::*;
#(
  parameter int unsigned CH         = 4,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  multi_edge_detect_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CH-1:0] stable_w;
  logic [CH-1:0] rise_w;
  logic [CH-1:0] fall_w;
  logic [CH-1:0] acc_rise_w;
  logic [CH-1:0] acc_fall_w;
  logic [CH-1:0] tick_d, tick_q;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    debounce_channel #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .level_i    (bus.level[i]),
      .stable_o   (stable_w[i]),
      .rise_o     (rise_w[i]),
      .fall_o     (fall_w[i]),
      .acc_rise_o (acc_rise_w[i]),
      .acc_fall_o (acc_fall_w[i])
    );
  end

  // Tick candidate per channel from this cycle's accept strobes and the current mode.
  always_comb begin
    tick_d = '0;
    for (int i = 0; i < CH; i++) begin
      tick_d[i] = tick_sel(bus.mode, acc_rise_w[i], acc_fall_w[i]);
    end
  end

  // Tick register, aligned with the channel rise/fall pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign bus.stable = stable_w;
  assign bus.rise   = rise_w;
  assign bus.fall   = fall_w;
  assign bus.tick   = tick_q;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed bench for multi_edge_detect: table of per-cycle vectors plus hand sequences for
// mode coverage, simultaneous accepts, reset mid-debounce and the DEB_CYCLES=1 case.
module tb_multi_edge_detect;

`ifdef MULTI_EDGE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int DEB = 4;

  logic clk;
  logic rst_n;

  multi_edge_detect_if #(.CH(4)) bus4 ();
  multi_edge_detect_if #(.CH(2)) bus1 ();

  multi_edge_detect #(
    .CH         (4),
    .DEB_CYCLES (DEB)
  ) u_dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus4)
  );

  multi_edge_detect #(
    .CH         (2),
    .DEB_CYCLES (1)
  ) u_dut1 (
    .clk (clk),
    .rst (rst_n),
    .bus (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] level;
    logic [1:0] mode;
    logic [3:0] st;
    logic [3:0] ri;
    logic [3:0] fa;
    logic [3:0] ti;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] lv, input logic [1:0] md, input logic [3:0] st,
                     input logic [3:0] ri, input logic [3:0] fa, input logic [3:0] ti);
    vec_t v;
    v.level = lv; v.mode = md; v.st = st; v.ri = ri; v.fa = fa; v.ti = ti;
    vecs.push_back(v);
  endtask

  initial begin
    int exp_tick [4];
    int n_r, n_f, n_t, n;
    exp_tick = '{1, 1, 2, 0};

    // Reset
    rst_n      = 1'b0;
    bus4.level = 4'b0000;
    bus4.mode  = 2'b00;
    bus1.level = 2'b00;
    bus1.mode  = 2'b10;
    cyc();
    cyc();
    chk("reset_stable", 32'(bus4.stable), 32'h0);
    chk("reset_rise",   32'(bus4.rise),   32'h0);
    chk("reset_fall",   32'(bus4.fall),   32'h0);
    chk("reset_tick",   32'(bus4.tick),   32'h0);
    rst_n = 1'b1;

    // DEB_CYCLES=1: single-cycle pulse passes unfiltered.
    bus1.level = 2'b01;
    cyc();
    bus1.level = 2'b00;
    for (int k = 0; k < SYNC_LAT; k++) cyc();
    chk("deb1_rise",   32'(bus1.rise),   32'h1);
    chk("deb1_stable", 32'(bus1.stable), 32'h1);
    chk("deb1_tick_r", 32'(bus1.tick),   32'h1);
    chk("deb1_nofall", 32'(bus1.fall),   32'h0);
    cyc();
    chk("deb1_fall",   32'(bus1.fall),   32'h1);
    chk("deb1_stab0",  32'(bus1.stable), 32'h0);
    chk("deb1_norise", 32'(bus1.rise),   32'h0);
    chk("deb1_tick_f", 32'(bus1.tick),   32'h1);
    cyc();
    chk("deb1_idle",   32'({bus1.rise, bus1.fall}), 32'h0);

    // Clean rise on channel 0 (mode rise).
    for (int k = 0; k < 5; k++) add(4'b0000, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < DEB - 1 + SYNC_LAT; k++)
      add(4'b0001, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 2'b00, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    add(4'b0001, 2'b00, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    // Glitch of 3 cycles on channel 1 is rejected.
    for (int k = 0; k < 3; k++) add(4'b0011, 2'b00, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 4 + SYNC_LAT; k++)
      add(4'b0001, 2'b00, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    // 3 high, 1 low, 4 high: one rise at the end of the final 4.
    for (int k = 0; k < 3; k++) add(4'b0011, 2'b00, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 2'b00, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < DEB - 1 + SYNC_LAT; k++)
      add(4'b0011, 2'b00, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0011, 2'b00, 4'b0011, 4'b0010, 4'b0000, 4'b0010);
    add(4'b0011, 2'b00, 4'b0011, 4'b0000, 4'b0000, 4'b0000);

    foreach (vecs[i]) begin
      bus4.level = vecs[i].level;
      bus4.mode  = vecs[i].mode;
      cyc();
      chk($sformatf("vec%0d_stable", i), 32'(bus4.stable), 32'(vecs[i].st));
      chk($sformatf("vec%0d_rise", i),   32'(bus4.rise),   32'(vecs[i].ri));
      chk($sformatf("vec%0d_fall", i),   32'(bus4.fall),   32'(vecs[i].fa));
      chk($sformatf("vec%0d_tick", i),   32'(bus4.tick),   32'(vecs[i].ti));
    end

    // Mode coverage on channel 2.
    for (int m = 0; m < 4; m++) begin
      n_r = 0; n_f = 0; n_t = 0;
      bus4.mode     = 2'(m);
      bus4.level[2] = 1'b1;
      for (int k = 0; k < 10; k++) begin
        cyc();
        n_r += int'(bus4.rise[2]); n_f += int'(bus4.fall[2]); n_t += int'(bus4.tick[2]);
      end
      bus4.level[2] = 1'b0;
      for (int k = 0; k < 10; k++) begin
        cyc();
        n_r += int'(bus4.rise[2]); n_f += int'(bus4.fall[2]); n_t += int'(bus4.tick[2]);
      end
      chk($sformatf("mode%0d_ticks", m), 32'(n_t), 32'(exp_tick[m]));
      chk($sformatf("mode%0d_rises", m), 32'(n_r), 32'd1);
      chk($sformatf("mode%0d_falls", m), 32'(n_f), 32'd1);
    end

    // Simultaneous rise on all channels, mode both.
    bus4.level = 4'b0000;
    for (int k = 0; k < 10; k++) cyc();
    bus4.mode  = 2'b10;
    bus4.level = 4'b1111;
    n = 0;
    while (bus4.rise == 4'b0000 && n < 20) begin
      cyc();
      n++;
    end
    chk("simul_latency", 32'(n),           32'(DEB + SYNC_LAT));
    chk("simul_rise",    32'(bus4.rise),   32'hf);
    chk("simul_tick",    32'(bus4.tick),   32'hf);
    chk("simul_stable",  32'(bus4.stable), 32'hf);

    // Reset mid-debounce on channel 3.
    bus4.level = 4'b0111;
    for (int k = 0; k < 10; k++) cyc();
    chk("pre_rst_stable", 32'(bus4.stable), 32'h7);
    bus4.level = 4'b1111;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rst_async_stable", 32'(bus4.stable), 32'h0);
    chk("rst_async_pulses", 32'({bus4.rise, bus4.fall, bus4.tick}), 32'h0);
    cyc();
    chk("rst_hold_stable", 32'(bus4.stable), 32'h0);
    chk("rst_hold_pulses", 32'({bus4.rise, bus4.fall, bus4.tick}), 32'h0);
    rst_n = 1'b1;
    n = 0;
    while (bus4.rise[3] == 1'b0 && n < 20) begin
      cyc();
      n++;
    end
    chk("post_rst_latency", 32'(n),         32'(DEB + SYNC_LAT));
    chk("post_rst_rise",    32'(bus4.rise), 32'hf);
    cyc();
    chk("post_rst_oneshot", 32'(bus4.rise), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_edge_detect.md
# multi_edge_detect

Multi-channel debounced edge detector for the bicycle-helper's mechanical inputs (brake levers, turn-signal buttons, wheel reed switch). Each channel filters its level input with a consecutive-sample debounce counter, tracks a stable level, and emits one-cycle rise/fall pulses plus a mode-selected `tick`. It sits between the raw pins and the control FSMs and replaces single-channel rising-edge detection.

## Interface
- `CH`, default 4: number of independent channels, ≥1.
- `DEB_CYCLES`, default 16: consecutive differing samples required to accept a new level, ≥1.
- `CNT_W`, default `$clog2(DEB_CYCLES+1)`: derived debounce counter width; not overridden.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserts immediately on low; releases synchronously to `clk` at top level).
- `level`  in  CH  raw per-channel input levels.
- `mode`  in  2  tick select, shared by all channels: 00 rise, 01 fall, 10 both, 11 disabled.
- `stable`  out  CH  debounced level per channel.
- `rise`  out  CH  one-cycle pulse on accepted 0→1.
- `fall`  out  CH  one-cycle pulse on accepted 1→0.
- `tick`  out  CH  one-cycle pulse per `mode`.

## Operation
- Per channel, with `s` the sampled level (synchronized if configured):
  - `s == stable`: counter cleared to 0.
  - `s != stable`, counter < DEB_CYCLES-1: counter +1.
  - `s != stable`, counter == DEB_CYCLES-1: accept. `stable <= s`, counter <= 0. Register `rise` (s=1) or `fall` (s=0).
- Any single sample equal to `stable` during counting restarts debounce from 0. A glitch shorter than DEB_CYCLES never changes `stable`.
- DEB_CYCLES=1: accept on the first differing sample. No filtering.
- `rise`, `fall`, `tick` are registered, high exactly one cycle per accept, never both on the same channel.
- `tick` = `rise` (00), `fall` (01), `rise|fall` (10), 0 (11).
- `mode` is sampled at the accepting edge. A mode change affects only later accepts. No pulse is regenerated.
- Channels are fully independent. Simultaneous accepts on several channels produce simultaneous pulses.
- Counter saturates structurally and never exceeds DEB_CYCLES-1. No wrap-around.

## Timing
- Reset values: `stable`=0, all counters 0, `rise`=`fall`=`tick`=0. Synchronizer flops are 0.
- Reset asserted mid-debounce or mid-pulse: all state clears immediately. No pulse is emitted for the interrupted change.
- Out of reset with `level` held high: a `rise` is emitted after normal debounce latency.
- Latency without sync: `level` changes before edge E0 and holds. `stable` and the pulse update at edge E0+DEB_CYCLES-1. The pulse is visible for the following cycle.
- Latency with sync: add 2 cycles.
- Back-to-back accepts on one channel are at least DEB_CYCLES cycles apart.

## Configuration
- `MULTI_EDGE_SYNC_EN` defined: each `level` bit passes through a 2-flop synchronizer (reset to 0) before debounce. Latency +2 cycles. Required for asynchronous pins.
- Undefined: `level` feeds debounce directly. Inputs must already be synchronous to `clk`.

## Structure
- Package `multi_edge_pkg` holds:
  - Mode constants `MODE_RISE`=2'b00, `MODE_FALL`=2'b01, `MODE_BOTH`=2'b10, `MODE_OFF`=2'b11.
  - Default `DEB_CYCLES`.
- Sub-module `debounce_channel` contains the optional synchronizer, counter, stable register, and rise/fall pulse registers. Top-level generates CH instances plus the shared `mode` → `tick` select.

## Test plan
- Reset / clean rise: CH=4, DEB_CYCLES=4, mode=00. Hold `level`=0000 5 cycles, then `level[0]`=1 held.
  - Required: `stable[0]`, `rise[0]`, `tick[0]` rise 4 cycles after the change (6 with sync). Pulses last 1 cycle; others stay 0.
- Glitch rejection: `level[1]` high for 3 cycles then low (DEB_CYCLES=4). Required: `stable[1]`=0, no `rise`/`tick`. Repeat with a 3-high, 1-low, 4-high pattern: exactly one `rise` at the end of the final 4.
- Mode coverage: toggle `level[2]` 0→1→0 with 10-cycle holds under modes 00, 01, 10, 11.
  - Required `tick[2]` counts: 1, 1, 2, 0. `rise`/`fall` are always 1 each.
- Simultaneous channels: all 4 `level` bits 0→1 in one cycle, mode=10. Required: `rise`=1111 and `tick`=1111 on the same cycle.
- Reset mid-debounce: `level[3]`=1 for 2 cycles, assert `rst`=0 for 1 cycle, release with `level[3]` held 1.
  - Required: all outputs 0 during reset. `rise[3]` comes a full DEB_CYCLES after release, not earlier.
- DEB_CYCLES=1: 1-cycle pulse on `level[0]`. Required: `rise[0]` then `fall[0]` on consecutive cycles, `stable[0]` follows with no filtering.
